// File: rtl/note_judge.sv
// note_judge: walks a beat map stored in an external synchronous ROM, times
// each note's approach in game ticks, opens a hit window around the note
// centre and judges the player's key inside it, pulsing hit or miss once
// per note and raising done when the end-of-map marker is read.
module note_judge #(
    parameter int TICK_DIV = 250000,
    parameter int GAP_W    = 8,
    parameter int ADDR_W   = 6,
    parameter int WIN      = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              map_en,
    input  logic              hit_key,
    output logic [ADDR_W-1:0] note_addr,
    input  logic [GAP_W-1:0]  note_gap,
    output logic              hit,
    output logic              miss,
    output logic              done,
    output logic              in_window,
    output logic [GAP_W-1:0]  countdown,
    output logic [ADDR_W:0]   score
);

    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    localparam logic [PRESC_W-1:0] TICK_LAST  = PRESC_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]   WIN_G      = GAP_W'(WIN);
    localparam logic [GAP_W-1:0]   WIN_P1_G   = GAP_W'(WIN + 1);
    localparam logic [GAP_W:0]     WIN_P1_W   = (GAP_W + 1)'(WIN + 1);
    localparam logic [GAP_W:0]     WLEFT_FULL = (GAP_W + 1)'(2 * WIN + 1);
    localparam logic [GAP_W:0]     WLEFT_ONE  = (GAP_W + 1)'(1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]    SCORE_MAX  = (ADDR_W + 1)'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_APPROACH,
        S_WINDOW,
        S_ADVANCE,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic                key_prev_q, key_prev_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [GAP_W-1:0]    cd_q, cd_d;
    logic [GAP_W:0]      wleft_q, wleft_d;
    logic [ADDR_W:0]     score_q, score_d;
    logic                hit_q, hit_d;
    logic                miss_q, miss_d;

    logic tick;
    logic press;

    assign tick  = (presc_q == TICK_LAST);
    assign press = hit_key & ~key_prev_q;

    assign note_addr = addr_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign done      = (state_q == S_FINISH);
    assign in_window = (state_q == S_WINDOW);
    assign countdown = cd_q;
    assign score     = score_q;

    // Next-state logic: prescaler, key edge history, note walk and hit judging.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        key_prev_d = hit_key;
        addr_d     = addr_q;
        cd_d       = cd_q;
        wleft_d    = wleft_q;
        score_d    = score_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;

        // The tick phase is re-anchored on every note load so approach timing
        // does not depend on how long the previous note took.
        if (state_q == S_IDLE || state_q == S_LOAD || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                addr_d  = '0;
                cd_d    = '0;
                wleft_d = '0;
                if (map_en) begin
                    score_d = '0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_LOAD;
            end

            S_LOAD: begin
                if (note_gap == '0) begin
                    cd_d    = '0;
                    state_d = S_FINISH;
                end else if (note_gap > WIN_G) begin
                    cd_d    = note_gap;
                    state_d = S_APPROACH;
                end else begin
                    cd_d    = note_gap;
                    wleft_d = {1'b0, note_gap} + WIN_P1_W;
                    state_d = S_WINDOW;
                end
            end

            S_APPROACH: begin
                if (tick) begin
                    cd_d = cd_q - 1'b1;
                    if (cd_q == WIN_P1_G) begin
                        wleft_d = WLEFT_FULL;
                        state_d = S_WINDOW;
                    end
                end
            end

            S_WINDOW: begin
                if (tick) begin
                    cd_d    = (cd_q == '0) ? '0 : cd_q - 1'b1;
                    wleft_d = wleft_q - 1'b1;
                end
                if (press) begin
                    hit_d   = 1'b1;
                    state_d = S_ADVANCE;
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + 1'b1;
                    end
                end else if (tick && wleft_q == WLEFT_ONE) begin
                    miss_d  = 1'b1;
                    state_d = S_ADVANCE;
                end
            end

            S_ADVANCE: begin
                if (addr_q == ADDR_LAST) begin
                    cd_d    = '0;
                    state_d = S_FINISH;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_FINISH: begin
                cd_d = '0;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Dropping map_en abandons the run at once; a judgement made on the
        // same cycle is discarded so control_path never sees a late pulse.
        if (state_q != S_IDLE && !map_en) begin
            state_d = S_IDLE;
            presc_d = '0;
            cd_d    = '0;
            score_d = score_q;
            hit_d   = 1'b0;
            miss_d  = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            key_prev_q <= 1'b0;
            addr_q     <= '0;
            cd_q       <= '0;
            wleft_q    <= '0;
            score_q    <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            key_prev_q <= key_prev_d;
            addr_q     <= addr_d;
            cd_q       <= cd_d;
            wleft_q    <= wleft_d;
            score_q    <= score_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

endmodule
